// File: rtl/mskaes_128bits_round_ctrl.sv
// Round sequencer for the 128-bit-per-cycle masked AES-128 core.
// Drives AddRoundKey, state, key-schedule and masked S-box enables, counts rounds, generates Rcon.
//
// Parameters:
//   NROUNDS - AES rounds after the initial key addition (default 10)
//   SB_LAT  - masked S-box layer latency in enabled cycles, >= 1 (default 4)
//
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  - block input handshake (plaintext and key shares on datapath)
//   out_valid / out_ready- ciphertext handshake (shares held in state register)
//   rnd_valid/ rnd_ready - fresh randomness handshake for the S-box gadgets
//   ak_sel_init          - AK operand select: 1 = input plaintext/key, 0 = round path
//   state_en             - state register load enable
//   key_load             - key register loads the input key shares
//   ks_en                - key register loads the next round key
//   sb_en                - S-box pipeline advance enable
//   mc_bypass            - skip MixColumns in the last round
//   rcon                 - round constant for the key schedule
//   round                - current round index, 0..NROUNDS
//   busy                 - a block is in flight
//
// Build option: define MSKAES_RND_STALL_EN to let rnd_valid=0 stall the S-box
// layer; otherwise rnd_valid is ignored and randomness is assumed always present.
module mskaes_128bits_round_ctrl #(
    parameter int NROUNDS = 10,
    parameter int SB_LAT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       rnd_valid,
    output logic       rnd_ready,
    output logic       ak_sel_init,
    output logic       state_en,
    output logic       key_load,
    output logic       ks_en,
    output logic       sb_en,
    output logic       mc_bypass,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy
);

    localparam int WCW = (SB_LAT > 1) ? $clog2(SB_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(SB_LAT - 1);
    localparam logic [3:0] LAST_RND = 4'(NROUNDS);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SB  = 2'd1;
    localparam logic [1:0] S_ROUND_AK = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]     r_fsm;
    logic [3:0]     r_round_cnt;
    logic [WCW-1:0] r_wait_cnt;
    logic [7:0]     r_rcon_q;

    logic       w_rnd;
    logic       w_in_idle;
    logic       w_in_wait;
    logic       w_in_ak;
    logic       w_in_done;
    logic       w_accept;
    logic       w_last_rnd;
    logic [7:0] w_xtime;

`ifdef MSKAES_RND_STALL_EN
    assign w_rnd = rnd_valid;
`else
    // Randomness is treated as always available; the OR keeps the port
    // referenced so both builds share one port list.
    assign w_rnd = rnd_valid | 1'b1;
`endif

    assign w_in_idle  = (r_fsm == S_IDLE);
    assign w_in_wait  = (r_fsm == S_WAIT_SB);
    assign w_in_ak    = (r_fsm == S_ROUND_AK);
    assign w_in_done  = (r_fsm == S_DONE);
    assign w_last_rnd = (r_round_cnt == LAST_RND);

    // Reset gates acceptance so no block is taken during the reset cycle.
    assign in_ready = w_in_idle & ~rst;
    assign w_accept = in_ready & in_valid;

    assign sb_en       = w_in_wait & w_rnd;
    assign rnd_ready   = sb_en;
    assign ak_sel_init = w_accept;
    assign key_load    = w_accept;
    assign state_en    = w_accept | w_in_ak;
    assign ks_en       = w_in_ak;
    assign mc_bypass   = w_in_ak & w_last_rnd;
    assign out_valid   = w_in_done;
    assign busy        = ~w_in_idle;
    assign rcon        = r_rcon_q;
    assign round       = r_round_cnt;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    assign w_xtime = {r_rcon_q[6:0], 1'b0} ^ (r_rcon_q[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_round_cnt <= 4'd0;
            r_wait_cnt  <= '0;
            r_rcon_q    <= 8'h01;
        end else begin
            unique case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        r_round_cnt <= 4'd1;
                        r_wait_cnt  <= '0;
                        r_rcon_q    <= 8'h01;
                        r_fsm       <= S_WAIT_SB;
                    end
                end
                S_WAIT_SB: begin
                    if (sb_en) begin
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_wait_cnt <= '0;
                            r_fsm      <= S_ROUND_AK;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                S_ROUND_AK: begin
                    if (w_last_rnd) begin
                        r_fsm <= S_DONE;
                    end else begin
                        r_round_cnt <= r_round_cnt + 4'd1;
                        r_rcon_q    <= w_xtime;
                        r_fsm       <= S_WAIT_SB;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mskaes_128bits_round_ctrl.md
Name: mskaes_128bits_round_ctrl

Overview:
- Round sequencer for the 128-bit-per-cycle masked AES-128 core.
- Drives enables and selects for the masked AddRoundKey XOR layer, state register, key-schedule register and masked S-box pipeline.
- Counts rounds and generates Rcon.
- Owns the input/output valid/ready handshakes; carries no shares itself, so it is order-independent.

Parameters:
- NROUNDS, 10: number of AES rounds after the initial key addition.
- SB_LAT, 4: latency in enabled cycles of the masked S-box layer, >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext and key shares valid on datapath inputs.
- in_ready  out  1  controller idle; accepts a block.
- out_valid  out  1  ciphertext shares valid in state register.
- out_ready  in  1  consumer takes ciphertext.
- rnd_valid  in  1  fresh randomness available for S-box gadgets.
- rnd_ready  out  1  randomness consumed this cycle.
- ak_sel_init  out  1  AK operand select: 1 = input plaintext/key, 0 = round path.
- state_en  out  1  state register load enable.
- key_load  out  1  key register loads input key shares.
- ks_en  out  1  key register loads next round key.
- sb_en  out  1  S-box pipeline advance enable.
- mc_bypass  out  1  skip MixColumns (last round).
- rcon  out  8  round constant for the key schedule.
- round  out  4  current round index, 0..NROUNDS.
- busy  out  1  block in flight (not IDLE).

Behaviour:
- FSM states: IDLE, WAIT_SB, ROUND_AK, DONE. Registers: fsm, round_cnt[3:0], wait_cnt (clog2(SB_LAT) bits), rcon_q[7:0].
- Reset (rst=1 at clock edge): fsm=IDLE, round_cnt=0, wait_cnt=0, rcon_q=8'h01.
  - All outputs are combinational from the registers and evaluate to 0, except rcon=8'h01.
  - in_ready is gated by ~rst, so it is 0 during the reset cycle.
  - Reset mid-operation abandons the block. No out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid=1: ak_sel_init=1, state_en=1, key_load=1 (initial AK). Then round_cnt<=1, wait_cnt<=0, rcon_q<=8'h01, go to WAIT_SB.
- WAIT_SB:
  - sb_en=rnd_valid, rnd_ready=rnd_valid.
  - wait_cnt increments only when sb_en=1.
  - When sb_en=1 and wait_cnt==SB_LAT-1: wait_cnt<=0, go to ROUND_AK.
  - rnd_valid=0 freezes the FSM and counter (stall).
- ROUND_AK (one cycle):
  - state_en=1, ks_en=1, ak_sel_init=0, mc_bypass=(round_cnt==NROUNDS).
  - If round_cnt==NROUNDS, go to DONE.
  - Else round_cnt<=round_cnt+1, rcon_q<=xtime(rcon_q), go to WAIT_SB.
  - xtime = {rcon_q[6:0],1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00).
- DONE:
  - out_valid=1, held until out_ready=1; then go to IDLE.
  - in_ready=0 in DONE. A new block is accepted only in the following IDLE cycle.
- Fixed outputs:
  - rcon=rcon_q. Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - round=round_cnt.
  - busy=(fsm!=IDLE).
- Latency without stalls: a block accepted at cycle t has out_valid at t+1+NROUNDS*(SB_LAT+1). With defaults this is t+51. Each rnd_valid=0 cycle in WAIT_SB adds 1.
- state_en, ks_en and key_load are never asserted in WAIT_SB or DONE.
- rnd_ready=0 outside WAIT_SB.

Optional Feature:
- Macro MSKAES_RND_STALL_EN.
- Defined: rnd_valid stall behaviour as above.
- Undefined: rnd_valid is ignored and treated as 1. sb_en=rnd_ready=1 throughout WAIT_SB. Latency is fixed at 1+NROUNDS*(SB_LAT+1).
- The port list is identical in both builds.

Test Plan:
- Single block, defaults, rnd_valid=1, out_ready=1: in_valid at cycle 0 -> key_load/state_en/ak_sel_init at cycle 0; out_valid at cycle 51; 10 ROUND_AK pulses at cycles 5,10,...,50; mc_bypass=1 only at cycle 50.
- Rcon check: rcon sampled at each ROUND_AK pulse -> 01,02,04,08,10,20,40,80,1b,36 in order.
- Stall (macro defined): rnd_valid=0 for 3 cycles during round 4 WAIT_SB -> out_valid at cycle 54; no sb_en, rnd_ready or state_en during the stall. Without the macro -> still cycle 51.
- Output backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid held, in_ready=0, in_valid ignored; after out_ready=1, IDLE, and the next block is accepted one cycle later.
- Reset mid-run: rst=1 at cycle 20 -> next cycle fsm=IDLE, round=0, rcon=01, all strobes 0, out_valid never asserted; a new block is then accepted normally.
- Back-to-back: in_valid held high, out_ready=1 -> blocks accepted at cycles 0 and 52; outputs at cycles 51 and 103.
